// File: rtl/l2_sram_pkg.sv
// Shared definitions for the L2 metadata SRAM wrapper.
//   l2_sram_state_e : sweep FSM state encoding (INIT, READY)
//   RD_LAT_MIN/MAX  : legal read-latency range of the array
package l2_sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } l2_sram_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/l2_sram_init_fsm.sv
// Initialisation sweep controller for the L2 metadata SRAM.
// Walks every address once after reset or on request, asserting a write
// enable each cycle, then reports the array ready.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   init_req    : request a new sweep (honoured only in READY)
//   init_we     : sweep write enable (high for every INIT cycle)
//   init_addr   : sweep write address
//   ready       : array accepts user requests
//
// state | meaning
// INIT  | sweeping, writing INIT_VAL at cnt, user requests dropped
// READY | sweep done, user requests accepted
module l2_sram_init_fsm
  import l2_sram_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  l2_sram_state_e    state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    unique case (state)
      INIT: begin
        init_we = 1'b1;
        // Leave on the cycle that writes the last entry; cnt never wraps.
        if (cnt == CNT_LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      READY: begin
        if (init_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign init_addr = cnt;
  assign ready     = (state == READY);

endmodule

// File: rtl/l2_meta_sram.sv
// Behavioural single-port L2 metadata SRAM with lane write mask, a
// self-initialising sweep and a 1- or 2-cycle read pipeline.
// Ports:
//   RW0_clk, RW0_rst_n : clock, async active-low reset
//   RW0_en, RW0_wmode  : request valid, 1 = write / 0 = read
//   RW0_addr           : request address
//   RW0_wdata/wmask    : write data, per-lane write enables
//   RW0_init_req       : restart the init sweep (from READY only)
//   RW0_ready          : array accepts requests
//   RW0_rdata/rvalid   : read result, one-cycle valid pulse
module l2_meta_sram
  import l2_sram_pkg::*;
#(
  parameter int              DATA_W   = 368,
  parameter int              ADDR_W   = 11,
  parameter int              MASK_W   = 8,
  parameter int              RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic [DATA_W-1:0] RW0_wdata,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic              RW0_init_req,
  output logic              RW0_ready,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid
);

  localparam int LW    = DATA_W / MASK_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if (DATA_W % MASK_W != 0) begin : g_bad_mask
    $error("l2_meta_sram: DATA_W must be a multiple of MASK_W");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("l2_meta_sram: RD_LAT must be 1 or 2");
  end

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem [DEPTH];

  l2_sram_init_fsm #(.ADDR_W(ADDR_W)) u_init_fsm (
    .clk       (RW0_clk),
    .rst_n     (RW0_rst_n),
    .init_req  (RW0_init_req),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (RW0_ready)
  );

  assign wr_acc = RW0_en & RW0_ready &  RW0_wmode;
  assign rd_acc = RW0_en & RW0_ready & ~RW0_wmode;

  // Single write port: the sweep owns it during INIT, users otherwise.
  // Contents are deliberately not reset; the sweep defines them.
  always_ff @(posedge RW0_clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VAL;
    end else if (wr_acc) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (RW0_wmask[i]) mem[RW0_addr][i*LW +: LW] <= RW0_wdata[i*LW +: LW];
      end
    end
  end

  // Array is sampled at the accept edge, so a write in the following cycle
  // cannot disturb a read already accepted.
  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        RW0_rvalid <= 1'b0;
        RW0_rdata  <= '0;
      end else begin
        RW0_rvalid <= rd_acc;
        if (rd_acc) RW0_rdata <= mem[RW0_addr];
      end
    end
  end else begin : g_lat2
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        s1_valid   <= 1'b0;
        s1_data    <= '0;
        RW0_rvalid <= 1'b0;
        RW0_rdata  <= '0;
      end else begin
        s1_valid   <= rd_acc;
        if (rd_acc) s1_data <= mem[RW0_addr];
        RW0_rvalid <= s1_valid;
        if (s1_valid) RW0_rdata <= s1_data;
      end
    end
  end

endmodule

// File: doc/l2_meta_sram.md
L2_META_SRAM -- requirements
Module: l2_meta_sram

Interface
REQ-001 SHALL have parameter DATA_W, default 368: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter MASK_W, default 8: write-mask lanes; DATA_W % MASK_W == 0 (elaboration error otherwise); lane width LW = DATA_W/MASK_W.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency, legal values 1 or 2 (elaboration error otherwise).
REQ-005 SHALL have parameter INIT_VAL, DATA_W bits, default 0: value written to every entry by the init sweep.
REQ-006 RW0_clk  input  1  sole clock, rising edge.
REQ-007 RW0_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 RW0_en  input  1  request valid.
REQ-009 RW0_wmode  input  1  1 = write, 0 = read.
REQ-010 RW0_addr  input  ADDR_W  request address.
REQ-011 RW0_wdata  input  DATA_W  write data.
REQ-012 RW0_wmask  input  MASK_W  lane enables; bit i covers wdata[i*LW +: LW].
REQ-013 RW0_init_req  input  1  request re-initialisation sweep.
REQ-014 RW0_ready  output  1  high = array accepts requests.
REQ-015 RW0_rdata  output  DATA_W  read data.
REQ-016 RW0_rvalid  output  1  one-cycle pulse, rdata carries a new read result.

Function
REQ-017 SHALL implement two states: INIT (sweep) and READY; RW0_ready = (state == READY), registered.
REQ-018 SHALL, in INIT, write INIT_VAL (all lanes) to address cnt each cycle, cnt counting 0 to 2**ADDR_W-1; on the cycle writing the last address, state goes to READY at the next edge; no counter wrap.
REQ-019 SHALL take exactly 2**ADDR_W cycles from the first rising edge with RW0_rst_n high to RW0_ready = 1.
REQ-020 SHALL accept a request on a rising edge where RW0_en && RW0_ready; requests with RW0_ready = 0 are dropped, no side effects.
REQ-021 SHALL, on an accepted write, update only lanes with wmask bit = 1 at that edge; other lanes unchanged; wmask = 0 is a legal no-op.
REQ-022 SHALL, on an accepted read at edge T, present ram[addr] on RW0_rdata with RW0_rvalid = 1 in the cycle after edge T+RD_LAT-1 (RD_LAT = 1: cycle after T; RD_LAT = 2: one cycle later).
REQ-023 SHALL hold RW0_rdata at the last read result when no new read completes; it never shows garbage or array contents for non-read cycles.
REQ-024 SHALL sustain one accepted request per cycle, with back-to-back reads returning in order.
REQ-025 SHALL, when RW0_init_req = 1 in READY, still perform any request accepted at that edge, then enter INIT with cnt = 0 at the same edge; RW0_ready drops the next cycle.
REQ-026 SHALL ignore RW0_init_req while in INIT; the sweep is not restarted.
REQ-027 SHALL complete a read in flight (RD_LAT = 2) when INIT is entered; rvalid/rdata deliver it normally.
REQ-028 SHALL read the pre-write value when a read and a write target the same address in consecutive cycles and the read was accepted first; a read accepted after a write returns the new data.

Reset
REQ-029 SHALL, on RW0_rst_n low, immediately set state = INIT, cnt = 0, RW0_ready = 0, RW0_rvalid = 0, RW0_rdata = 0, and clear the read pipeline.
REQ-030 SHALL not reset array contents; contents are defined only after the sweep completes, including after reset mid-sweep or mid-read.

Structure
REQ-031 SHALL place the state enum (INIT, READY) and the legal RD_LAT values in shared package l2_sram_pkg.
REQ-032 SHALL implement the sweep FSM and counter in sub-module l2_sram_init_fsm (outputs: init write enable, init address, ready).
REQ-033 SHALL model storage as a single behavioural array with one write port muxed between init and user paths.

Verification (ADDR_W=4, DATA_W=16, MASK_W=2, INIT_VAL=16'hA5A5)
REQ-034 Reset release -> RW0_ready rises exactly 16 cycles later; reads of addr 0..15 all return 16'hA5A5, with rvalid after RD_LAT cycles.
REQ-035 Write addr 3 data 16'h1234 mask 2'b01, then read 3 -> 16'hA534; mask 2'b10 data 16'hFF00, then read -> 16'hFF34.
REQ-036 Read addr 5, then 4 idle cycles -> rvalid pulses once, rdata stays at 16'hA5A5 throughout idle.
REQ-037 RD_LAT=2: reads of addr 1, 2, 3 back-to-back with init_req asserted alongside the read of 3 -> three in-order results, ready low 16 cycles, then all entries 16'hA5A5.
REQ-038 Assert RW0_rst_n low at sweep cnt = 7 with a request present -> ready, rvalid, rdata go 0 asynchronously; full 16-cycle sweep restarts at release; the request is dropped.
